// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI register bridge: FSM encoding, command
// entry layout and the abort-counter width.
package spi_reg_bridge_pkg;

  // FSM encoding
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_REQ  = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ
  } state_e;

  // Default widths and the resulting command entry width {we, addr, wdata}
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int CMD_W          = 1 + DEF_ADDR_WIDTH + DEF_DATA_WIDTH;

  // Entry field offsets: wdata occupies the low bits, then addr, then we
  localparam int CMD_WDATA_LSB = 0;

  // Width of the REQ-cycle counter; covers the full 2..65535 abort range
  localparam int TMO_CNT_W = 16;

  function automatic int cmd_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  function automatic int cmd_addr_lsb(input int dw);
    return CMD_WDATA_LSB + dw;
  endfunction

  function automatic int cmd_we_bit(input int aw, input int dw);
    return CMD_WDATA_LSB + dw + aw;
  endfunction

endpackage

// File: rtl/spi_reg_cmd_fifo.sv
// Command FIFO with first-word fall-through: the head entry is visible on
// pop_data_o whenever empty_o is low. A push while full is dropped even if
// a pop happens in the same cycle.
module spi_reg_cmd_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Fullness is judged on the current state only, so a pop cannot make room
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok_s  = push_i && !full_o;
  assign pop_ok_s   = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless until written so no reset
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// Bridges SPI slave register strobes onto a req/ack register bus. Commands
// are queued, issued in order, and read data is returned in issue order.
// Hung accesses are aborted after TIMEOUT_CYC request cycles.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 16,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          TIMEOUT_CYC  = 64,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slave_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] slave_addr_i,
  input  logic [DATA_WIDTH-1:0] slave_wr_data_i,
  input  logic                  slave_rd_en_i,
  output logic                  slave_rd_vld_o,
  output logic [DATA_WIDTH-1:0] slave_rd_data_o,
  output logic                  reg_req_o,
  output logic                  reg_we_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  input  logic                  reg_ack_i,
  input  logic [DATA_WIDTH-1:0] reg_rdata_i,
  input  logic                  err_clr_i,
  output logic                  cmd_ovf_o,
  output logic                  timeout_o
);

  localparam int CW       = cmd_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int WE_BIT   = cmd_we_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int ADDR_LSB = cmd_addr_lsb(DATA_WIDTH);

  localparam logic [DATA_WIDTH-1:0] TMO_DATA = DATA_WIDTH'(TIMEOUT_DATA);
  localparam logic [TMO_CNT_W-1:0]  TMO_LAST = TMO_CNT_W'(TIMEOUT_CYC - 1);

  // Command capture
  logic                  push_req_s;
  logic                  push_s;
  logic [CW-1:0]         push_data_s;
  logic                  ovf_set_s;

  // FIFO head
  logic [CW-1:0]         head_s;
  logic                  head_we_s;
  logic [ADDR_WIDTH-1:0] head_addr_s;
  logic [DATA_WIDTH-1:0] head_wdata_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  pop_s;

  // FSM and bus registers
  state_e                state_q,   state_d;
  logic                  req_q,     req_d;
  logic                  we_q,      we_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [TMO_CNT_W-1:0]  cnt_q,     cnt_d;
  logic                  rd_vld_q,  rd_vld_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ovf_q,     ovf_d;
  logic                  tmo_q,     tmo_d;
  logic                  tmo_set_s;
  logic                  done_s;

  // Strobe to entry: a write always wins over a simultaneous read
  always_comb begin
    push_req_s  = 1'b0;
    push_data_s = '0;
    if (slave_wr_en_i) begin
      push_req_s  = 1'b1;
      push_data_s = {1'b1, slave_addr_i, slave_wr_data_i};
    end else if (slave_rd_en_i) begin
      push_req_s  = 1'b1;
      push_data_s = {1'b0, slave_addr_i, {DATA_WIDTH{1'b0}}};
    end else begin
      push_req_s  = 1'b0;
      push_data_s = '0;
    end
  end

  assign push_s    = push_req_s && !fifo_full_s;
  assign ovf_set_s = (slave_wr_en_i && slave_rd_en_i) || (push_req_s && fifo_full_s);

  spi_reg_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  assign head_we_s    = head_s[WE_BIT];
  assign head_addr_s  = head_s[WE_BIT-1:ADDR_LSB];
  assign head_wdata_s = head_s[ADDR_LSB-1:0];

  // An access ends on ack, or on the terminal REQ cycle without ack
  assign done_s = (state_q == S_REQ) && (reg_ack_i || (cnt_q == TMO_LAST));

  // FSM next-state, issue, read return and abort handling
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rd_vld_d  = 1'b0;
    rd_data_d = rd_data_q;
    pop_s     = 1'b0;
    tmo_set_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = head_we_s;
          addr_d  = head_addr_s;
          wdata_d = head_wdata_s;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      S_REQ: begin
        // Completion side: ack beats an abort in the same cycle
        if (reg_ack_i) begin
          rd_vld_d  = !we_q;
          rd_data_d = we_q ? rd_data_q : reg_rdata_i;
        end else if (cnt_q == TMO_LAST) begin
          tmo_set_s = 1'b1;
          rd_vld_d  = !we_q;
          rd_data_d = we_q ? rd_data_q : TMO_DATA;
        end else begin
          cnt_d = cnt_q + TMO_CNT_W'(1);
        end
        // Issue side: chain straight into the next command when one waits
        if (done_s) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            state_d = S_REQ;
            req_d   = 1'b1;
            we_d    = head_we_s;
            addr_d  = head_addr_s;
            wdata_d = head_wdata_s;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end else begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Sticky error flags; a new error in the clearing cycle survives
  always_comb begin
    ovf_d = ovf_set_s || (ovf_q && !err_clr_i);
    tmo_d = tmo_set_s || (tmo_q && !err_clr_i);
  end

  // State, bus and return registers; reset drops any access in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
    end
  end

  assign reg_req_o       = req_q;
  assign reg_we_o        = we_q;
  assign reg_addr_o      = addr_q;
  assign reg_wdata_o     = wdata_q;
  assign slave_rd_vld_o  = rd_vld_q;
  assign slave_rd_data_o = rd_data_q;
  assign cmd_ovf_o       = ovf_q;
  assign timeout_o       = tmo_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: table-driven single commands,
// hand-written corner sequences and a randomized phase against a
// queue-based reference model. The bench also plays the register banks.
module tb_spi_reg_bridge;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int TMO = 64;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          slave_wr_en_i = 1'b0;
  logic [AW-1:0] slave_addr_i = '0;
  logic [DW-1:0] slave_wr_data_i = '0;
  logic          slave_rd_en_i = 1'b0;
  logic          slave_rd_vld_o;
  logic [DW-1:0] slave_rd_data_o;
  logic          reg_req_o;
  logic          reg_we_o;
  logic [AW-1:0] reg_addr_o;
  logic [DW-1:0] reg_wdata_o;
  logic          reg_ack_i = 1'b0;
  logic [DW-1:0] reg_rdata_i = '0;
  logic          err_clr_i = 1'b0;
  logic          cmd_ovf_o;
  logic          timeout_o;

  spi_reg_bridge dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .slave_wr_en_i   (slave_wr_en_i),
    .slave_addr_i    (slave_addr_i),
    .slave_wr_data_i (slave_wr_data_i),
    .slave_rd_en_i   (slave_rd_en_i),
    .slave_rd_vld_o  (slave_rd_vld_o),
    .slave_rd_data_o (slave_rd_data_o),
    .reg_req_o       (reg_req_o),
    .reg_we_o        (reg_we_o),
    .reg_addr_o      (reg_addr_o),
    .reg_wdata_o     (reg_wdata_o),
    .reg_ack_i       (reg_ack_i),
    .reg_rdata_i     (reg_rdata_i),
    .err_clr_i       (err_clr_i),
    .cmd_ovf_o       (cmd_ovf_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t          exp_cmd_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] bank_mem  [logic [AW-1:0]];

  // Unwritten registers read back as address + 0xA000
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    else return DW'(a) + 32'h0000_A000;
  endfunction

  function automatic logic [DW-1:0] bank_read(input logic [AW-1:0] a);
    if (bank_mem.exists(a)) return bank_mem[a];
    else return DW'(a) + 32'h0000_A000;
  endfunction

  task automatic model_accept(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = we ? d : '0;
    exp_cmd_q.push_back(c);
    if (we) model_mem[a] = d;
    else exp_rd_q.push_back(model_read(a));
  endtask

  // ---------------- register-bank responder and monitor ----------------
  logic ack_en      = 1'b0;
  bit   rand_delay  = 1'b0;
  int   fixed_delay = 0;
  int   cur_delay   = 0;
  int   wait_cnt    = 0;
  int   hold_cnt    = 0;
  int   completions = 0;
  int   req_cycles  = 0;
  logic prev_req    = 1'b0;
  logic prev_ack    = 1'b0;
  cmd_t prev_cmd    = '0;
  int   vld_cyc_q[$];

  // Checks returns and bus stability, then drives ack/rdata for the next edge
  always @(negedge clk_i) begin
    cmd_t cur;
    cmd_t c;
    cur = {reg_we_o, reg_addr_o, reg_wdata_o};
    if (slave_rd_vld_o) begin
      vld_cyc_q.push_back(cyc);
      if (exp_rd_q.size() == 0) check("rd_vld_unexpected", slave_rd_vld_o, 1'b0);
      else check("rd_data_order", slave_rd_data_o, exp_rd_q.pop_front());
    end
    if (reg_req_o) begin
      req_cycles++;
      if (prev_req && !prev_ack && hold_cnt < TMO) begin
        check("bus_hold", cur, prev_cmd);
        hold_cnt++;
      end else begin
        hold_cnt = 1;
      end
    end else begin
      hold_cnt = 0;
    end
    prev_req = reg_req_o;
    prev_cmd = cur;
    if (reg_req_o && ack_en) begin
      if (wait_cnt >= cur_delay) begin
        if (exp_cmd_q.size() == 0) begin
          check("bus_access_unexpected", reg_req_o, 1'b0);
        end else begin
          c = exp_cmd_q.pop_front();
          check("bus_we", reg_we_o, c.we);
          check("bus_addr", reg_addr_o, c.addr);
          if (c.we) check("bus_wdata", reg_wdata_o, c.wdata);
        end
        if (reg_we_o) begin
          bank_mem[reg_addr_o] = reg_wdata_o;
          reg_rdata_i = $urandom;
        end else begin
          reg_rdata_i = bank_read(reg_addr_o);
        end
        reg_ack_i = 1'b1;
        completions++;
        wait_cnt  = 0;
        cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
      end else begin
        reg_ack_i   = 1'b0;
        reg_rdata_i = $urandom;
        wait_cnt++;
      end
    end else begin
      // Stray acks while req is low must be ignored by the bridge
      reg_ack_i   = (rand_delay && !reg_req_o) ? ($urandom_range(0, 3) == 0) : 1'b0;
      reg_rdata_i = $urandom;
      wait_cnt    = 0;
      cur_delay   = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
    end
    prev_ack = reg_ack_i;
  end

  // ---------------- stimulus helpers ----------------
  task automatic strobe(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    slave_wr_en_i   = wr;
    slave_rd_en_i   = rd;
    slave_addr_i    = a;
    slave_wr_data_i = d;
    @(negedge clk_i);
    slave_wr_en_i = 1'b0;
    slave_rd_en_i = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string name);
    int k;
    for (k = 0; k < limit; k++) begin
      if (exp_cmd_q.size() == 0 && exp_rd_q.size() == 0 && !reg_req_o) break;
      @(negedge clk_i);
    end
    if (k == limit) check(name, {exp_cmd_q.size(), exp_rd_q.size(), 31'd0, reg_req_o}, '0);
    repeat (2) @(negedge clk_i);
  endtask

  function automatic logic [84:0] all_outputs();
    return {slave_rd_vld_o, slave_rd_data_o, reg_req_o, reg_we_o, reg_addr_o,
            reg_wdata_o, cmd_ovf_o, timeout_o};
  endfunction

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic          exp_ovf;
    int            exp_vld;
    logic [DW-1:0] exp_data;
    int            exp_req;
  } vec_t;

  vec_t vec[8];

  // Hard stop in case the design wedges somewhere unbounded
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, r0, c0, t0, req_cnt, rand_acc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int r;

    vec[0] = '{1'b1, 1'b0, 16'h0010, 32'h1234_5678, 2, 1'b0, 0, 32'h0000_0000, 3};
    vec[1] = '{1'b0, 1'b1, 16'h0010, 32'h0000_0000, 0, 1'b0, 1, 32'h1234_5678, 1};
    vec[2] = '{1'b0, 1'b1, 16'h0200, 32'h0000_0000, 1, 1'b0, 1, 32'h0000_A200, 2};
    vec[3] = '{1'b1, 1'b1, 16'h0300, 32'hCAFE_F00D, 0, 1'b1, 0, 32'h0000_0000, 1};
    vec[4] = '{1'b0, 1'b1, 16'h0300, 32'h0000_0000, 3, 1'b0, 1, 32'hCAFE_F00D, 4};
    vec[5] = '{1'b1, 1'b0, 16'hFFFF, 32'hFFFF_FFFF, 0, 1'b0, 0, 32'h0000_0000, 1};
    vec[6] = '{1'b0, 1'b1, 16'hFFFF, 32'h0000_0000, 0, 1'b0, 1, 32'hFFFF_FFFF, 1};
    vec[7] = '{1'b0, 1'b1, 16'h0001, 32'h0000_0000, 1, 1'b0, 1, 32'h0000_A001, 2};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("reset_outputs", all_outputs(), '0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_outputs", all_outputs(), '0);

    // Table of single commands, each drained before the next
    ack_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fixed_delay = vec[i].delay;
      clear_errors();
      v0 = vld_cyc_q.size();
      r0 = req_cycles;
      if (vec[i].wr) model_accept(1'b1, vec[i].addr, vec[i].wdata);
      else if (vec[i].rd) model_accept(1'b0, vec[i].addr, '0);
      strobe(vec[i].wr, vec[i].rd, vec[i].addr, vec[i].wdata);
      wait_drain(40, $sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_ovf", i), cmd_ovf_o, vec[i].exp_ovf);
      check($sformatf("vec%0d_vld_count", i), vld_cyc_q.size() - v0, vec[i].exp_vld);
      check($sformatf("vec%0d_req_cycles", i), req_cycles - r0, vec[i].exp_req);
      if (vec[i].exp_vld != 0) check($sformatf("vec%0d_rd_data", i), slave_rd_data_o, vec[i].exp_data);
    end

    // Read burst with zero-wait ack: 3-cycle latency, one return per cycle
    fixed_delay = 0;
    v0 = vld_cyc_q.size();
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      a = 16'h0100 + AW'(4 * i);
      model_accept(1'b0, a, '0);
      strobe(1'b0, 1'b1, a, '0);
    end
    wait_drain(40, "burst_drain");
    check("burst_vld_count", vld_cyc_q.size() - v0, 8);
    if (vld_cyc_q.size() - v0 == 8) begin
      check("burst_first_latency", vld_cyc_q[v0] - t0, 3);
      for (int i = 1; i < 8; i++)
        check($sformatf("burst_pulse%0d_cycle", i), vld_cyc_q[v0 + i] - vld_cyc_q[v0], i);
    end
    check("burst_last_data", slave_rd_data_o, 32'h0000_A11C);

    // Read with no ack: aborted after exactly TMO request cycles
    ack_en = 1'b0;
    v0 = vld_cyc_q.size();
    exp_rd_q.push_back(32'hDEAD_BEEF);
    strobe(1'b0, 1'b1, 16'h0040, '0);
    req_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (reg_req_o) req_cnt++;
      else if (req_cnt > 0) break;
      @(negedge clk_i);
    end
    @(negedge clk_i);
    check("timeout_req_cycles", req_cnt, TMO);
    check("timeout_flag", timeout_o, 1'b1);
    check("timeout_vld_count", vld_cyc_q.size() - v0, 1);
    check("timeout_rd_data", slave_rd_data_o, 32'hDEAD_BEEF);
    clear_errors();
    check("timeout_cleared", timeout_o, 1'b0);

    // Ack in the terminal cycle wins over the abort
    ack_en = 1'b1;
    fixed_delay = TMO - 1;
    v0 = vld_cyc_q.size();
    model_accept(1'b0, 16'h0044, '0);
    strobe(1'b0, 1'b1, 16'h0044, '0);
    wait_drain(120, "terminal_ack_drain");
    check("terminal_ack_no_timeout", timeout_o, 1'b0);
    check("terminal_ack_vld_count", vld_cyc_q.size() - v0, 1);
    check("terminal_ack_data", slave_rd_data_o, 32'h0000_A044);

    // 20 writes with the bus stalled: 17 accepted, the rest dropped
    ack_en = 1'b0;
    fixed_delay = 0;
    c0 = completions;
    v0 = vld_cyc_q.size();
    for (int i = 0; i < 20; i++) begin
      a = 16'h0500 + AW'(4 * i);
      d = 32'hF000_0000 + DW'(i);
      if (i < 17) model_accept(1'b1, a, d);
      strobe(1'b1, 1'b0, a, d);
    end
    check("full_ovf", cmd_ovf_o, 1'b1);
    // A push into a full FIFO in the cycle of the first pop is still dropped
    @(posedge clk_i);
    ack_en = 1'b1;
    @(negedge clk_i);
    strobe(1'b1, 1'b0, 16'h0600, 32'h5555_AAAA);
    wait_drain(80, "full_drain");
    check("full_completions", completions - c0, 17);
    check("full_no_vld", vld_cyc_q.size() - v0, 0);

    // Reset mid-access with five reads still queued
    clear_errors();
    ack_en = 1'b0;
    for (int i = 0; i < 6; i++) strobe(1'b0, 1'b1, 16'h0700 + AW'(4 * i), '0);
    repeat (3) @(negedge clk_i);
    check("rst_mid_pre_req", reg_req_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid_outputs", all_outputs(), '0);
    rst_i = 1'b0;
    ack_en = 1'b1;
    v0 = vld_cyc_q.size();
    r0 = req_cycles;
    repeat (30) @(negedge clk_i);
    check("rst_mid_no_vld", vld_cyc_q.size() - v0, 0);
    check("rst_mid_no_req", req_cycles - r0, 0);

    // Randomized traffic against the model, bus delays 0..3 plus stray acks
    rand_delay = 1'b1;
    c0 = completions;
    rand_acc = 0;
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 3));
      if (r < 2 && (rand_acc - (completions - c0)) < 12) begin
        a = AW'(4 * $urandom_range(0, 7));
        d = $urandom;
        if (r == 0) begin
          model_accept(1'b1, a, d);
          strobe(1'b1, 1'b0, a, d);
        end else begin
          model_accept(1'b0, a, '0);
          strobe(1'b0, 1'b1, a, '0);
        end
        rand_acc++;
      end else begin
        @(negedge clk_i);
      end
    end
    rand_delay = 1'b0;
    wait_drain(300, "random_drain");
    check("random_completions", completions - c0, rand_acc);
    check("random_no_errors", {cmd_ovf_o, timeout_o}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
